// File: rtl/uart_pkg.sv
// -----------------------------------------------------------------------------
// uart_pkg
// Shared UART definitions used by the parametrised transmitter (and the
// matching receiver): parity mode encoding, one-hot state encodings, the
// frame bit-counter width and the parity helper.
// Optional feature macro used by the transmitter: UART_TX_HOLD_REG_EN.
// -----------------------------------------------------------------------------
package uart_pkg;

    // Parity mode as presented on the parity_mode input.
    typedef enum logic [1:0] {
        PAR_NONE  = 2'b00,
        PAR_EVEN  = 2'b01,
        PAR_ODD   = 2'b10,
        PAR_SPACE = 2'b11   // constant 0 in the parity slot
    } parity_e;

    // One-hot state bit positions and the matching encodings.
    localparam int STATE_W    = 5;
    localparam int IDX_IDLE   = 0;
    localparam int IDX_START  = 1;
    localparam int IDX_DATA   = 2;
    localparam int IDX_PARITY = 3;
    localparam int IDX_STOP   = 4;

    localparam logic [STATE_W-1:0] ST_IDLE   = 5'b00001;
    localparam logic [STATE_W-1:0] ST_START  = 5'b00010;
    localparam logic [STATE_W-1:0] ST_DATA   = 5'b00100;
    localparam logic [STATE_W-1:0] ST_PARITY = 5'b01000;
    localparam logic [STATE_W-1:0] ST_STOP   = 5'b10000;

    // Bit position within a frame: start(0) + up to 9 data + parity + 2 stop
    // is at most 13, so 4 bits are always enough.
    localparam int BIT_CNT_W = 4;

    // Parity bit for a frame given the XOR of its data bits.
    function automatic logic parity_bit(input parity_e mode, input logic data_xor);
        case (mode)
            PAR_EVEN: return data_xor;
            PAR_ODD:  return ~data_xor;
            default:  return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/uart_bit_timer.sv
// -----------------------------------------------------------------------------
// uart_bit_timer
// Oversample tick counter plus frame bit counter. The tick counter advances on
// each enabled tick and wraps at N_TICKS-1; the wrap is reported on bit_end
// and advances bit_cnt (bit position within the current frame).
//
// Ports:
//   clock    in   system clock, rising edge
//   reset    in   synchronous active-high reset
//   clear    in   zero both counters (has priority over enable)
//   enable   in   count this cycle (baud tick while a frame is active)
//   bit_end  out  last tick of the current bit period is being counted
//   bit_cnt  out  bit position within the frame, 0 = start bit
// -----------------------------------------------------------------------------
module uart_bit_timer
    import uart_pkg::*;
#(
    parameter int N_TICKS      = 16,
    parameter int N_CONT_TICKS = 4
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic                 clear,
    input  logic                 enable,
    output logic                 bit_end,
    output logic [BIT_CNT_W-1:0] bit_cnt
);

    localparam logic [N_CONT_TICKS-1:0] TICK_LAST = N_CONT_TICKS'(N_TICKS - 1);

    logic [N_CONT_TICKS-1:0] tick_q;
    logic [BIT_CNT_W-1:0]    bit_q;

    assign bit_end = enable && (tick_q == TICK_LAST);
    assign bit_cnt = bit_q;

    // NOTE: state registers use non-blocking assignments so every flop samples
    // the pre-edge values of the others, independent of block ordering.
    always_ff @(posedge clock) begin
        if (reset || clear) begin
            tick_q <= '0;
            bit_q  <= '0;
        end else if (enable) begin
            if (tick_q == TICK_LAST) begin
                tick_q <= '0;
                bit_q  <= bit_q + 1'b1;
            end else begin
                tick_q <= tick_q + 1'b1;
            end
        end
    end

endmodule

// File: rtl/uart_tx_param.sv
// -----------------------------------------------------------------------------
// uart_tx_param
// Parametrised UART serializer: start bit, N_BITS_DATA data bits LSB first,
// optional parity (even/odd/space) and one or two stop bits, each bit lasting
// N_TICKS baud oversample ticks. Bytes arrive over a valid/ready handshake;
// data and frame configuration are captured on accept.
//
// Optional feature: define UART_TX_HOLD_REG_EN to add a one-entry holding
// register (with its own configuration copy) so the next byte can be accepted
// mid-frame and sent back-to-back with no idle cycle.
//
// Ports:
//   clock        in   system clock, rising edge
//   reset        in   synchronous active-high reset
//   s_ticks      in   baud oversample strobe, one clock wide
//   tx_valid     in   tx_data_in holds a byte to send
//   tx_data_in   in   byte to transmit, LSB first
//   tx_ready     out  a byte is accepted this cycle if tx_valid
//   parity_mode  in   00 none, 01 even, 10 odd, 11 space
//   stop_two     in   1 = two stop bits
//   tx_busy      out  frame in progress
//   tx_done_o    out  one-cycle pulse after the final stop bit
//   tx_data_out  out  serial line, idle high
// -----------------------------------------------------------------------------
module uart_tx_param
    import uart_pkg::*;
#(
    parameter int N_BITS_DATA  = 8,
    parameter int N_TICKS      = 16,
    parameter int N_CONT_TICKS = 4,
    parameter int N_BITS_STATE = 5
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic                   s_ticks,
    input  logic                   tx_valid,
    input  logic [N_BITS_DATA-1:0] tx_data_in,
    output logic                   tx_ready,
    input  logic [1:0]             parity_mode,
    input  logic                   stop_two,
    output logic                   tx_busy,
    output logic                   tx_done_o,
    output logic                   tx_data_out
);

    // Everything a frame needs once it has been accepted.
    typedef struct packed {
        logic [N_BITS_DATA-1:0] data;      // shifted right as bits go out
        logic                   par_en;
        logic                   par_bit;
        logic                   stop_two;
    } frame_t;

    localparam logic [BIT_CNT_W-1:0] DATA_LAST = BIT_CNT_W'(N_BITS_DATA);

    logic [N_BITS_STATE-1:0] state_q, state_d;
    frame_t                  frame_q, frame_in, frame_next;
    logic                    done_q;
    logic                    in_idle, ready_int, accept, start_new;
    logic                    timer_en, timer_clear, bit_end, frame_end;
    logic [BIT_CNT_W-1:0]    bit_cnt, stop_last;

    assign in_idle = state_q[IDX_IDLE];
    assign accept  = tx_valid && ready_int;

    // Snapshot of the byte and configuration currently offered.
    always_comb begin
        frame_in.data     = tx_data_in;
        frame_in.par_en   = (parity_e'(parity_mode) != PAR_NONE);
        frame_in.par_bit  = parity_bit(parity_e'(parity_mode), ^tx_data_in);
        frame_in.stop_two = stop_two;
    end

`ifdef UART_TX_HOLD_REG_EN
    frame_t hold_q;
    logic   hold_full_q;

    // A new frame starts from IDLE, or straight out of the last stop bit when
    // a byte is waiting (or arrives on that very edge).
    assign start_new  = (in_idle && accept) || (frame_end && (hold_full_q || accept));
    assign frame_next = hold_full_q ? hold_q : frame_in;
    assign ready_int  = !hold_full_q;

    always_ff @(posedge clock) begin
        if (reset) begin
            hold_q      <= '0;
            hold_full_q <= 1'b0;
        end else if (accept && !start_new) begin
            hold_q      <= frame_in;
            hold_full_q <= 1'b1;
        end else if (start_new && hold_full_q) begin
            hold_full_q <= 1'b0;
        end
    end
`else
    assign start_new  = in_idle && accept;
    assign frame_next = frame_in;
    assign ready_int  = in_idle;
`endif

    // Ticks are ignored in IDLE, which also keeps a tick coincident with
    // accept from being counted. Counters restart at every frame boundary.
    assign timer_en    = s_ticks && !in_idle;
    assign timer_clear = in_idle || frame_end;

    uart_bit_timer #(
        .N_TICKS      (N_TICKS),
        .N_CONT_TICKS (N_CONT_TICKS)
    ) u_bit_timer (
        .clock   (clock),
        .reset   (reset),
        .clear   (timer_clear),
        .enable  (timer_en),
        .bit_end (bit_end),
        .bit_cnt (bit_cnt)
    );

    // Frame positions: 0 start, 1..N data, N+1 parity (if present), then the
    // stop bits; the final stop sits at N + P + S.
    assign stop_last = DATA_LAST + BIT_CNT_W'(frame_q.par_en)
                     + (frame_q.stop_two ? BIT_CNT_W'(2) : BIT_CNT_W'(1));
    assign frame_end = state_q[IDX_STOP] && bit_end && (bit_cnt == stop_last);

    // State register plus frame shifter and done pulse.
    // NOTE: the frame register is reset along with the FSM so the shifter and
    // parity slot come out of reset in a known all-zero state.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= N_BITS_STATE'(ST_IDLE);
            frame_q <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            done_q  <= frame_end;
            if (start_new) begin
                frame_q <= frame_next;
            end else if (state_q[IDX_DATA] && bit_end) begin
                frame_q.data <= frame_q.data >> 1;
            end
        end
    end

    // Next-state logic.
    // NOTE: state_d is given a default before the case so no path leaves it
    // unassigned, which would otherwise infer a latch.
    always_comb begin
        state_d = state_q;
        case (1'b1)
            state_q[IDX_IDLE]: begin
                if (start_new) state_d = N_BITS_STATE'(ST_START);
            end
            state_q[IDX_START]: begin
                if (bit_end) state_d = N_BITS_STATE'(ST_DATA);
            end
            state_q[IDX_DATA]: begin
                if (bit_end && (bit_cnt == DATA_LAST))
                    state_d = frame_q.par_en ? N_BITS_STATE'(ST_PARITY)
                                             : N_BITS_STATE'(ST_STOP);
            end
            state_q[IDX_PARITY]: begin
                if (bit_end) state_d = N_BITS_STATE'(ST_STOP);
            end
            state_q[IDX_STOP]: begin
                if (frame_end)
                    state_d = start_new ? N_BITS_STATE'(ST_START)
                                        : N_BITS_STATE'(ST_IDLE);
            end
            default: state_d = N_BITS_STATE'(ST_IDLE);  // recover from a non-one-hot value
        endcase
    end

    // Outputs.
    always_comb begin
        tx_ready    = ready_int;
        tx_busy     = !in_idle;
        tx_done_o   = done_q;
        tx_data_out = 1'b1;
        case (1'b1)
            state_q[IDX_START]:  tx_data_out = 1'b0;
            state_q[IDX_DATA]:   tx_data_out = frame_q.data[0];
            state_q[IDX_PARITY]: tx_data_out = frame_q.par_bit;
            default:             tx_data_out = 1'b1;
        endcase
    end

endmodule

// File: tb/tb_uart_tx_param.sv
// -----------------------------------------------------------------------------
// tb_uart_tx_param
// Self-checking bench for uart_tx_param (default parameters). The expected
// line waveform of each frame is built as a list of bit values from the
// frame's data, parity mode and stop count; each bit must hold for N_TICKS
// baud ticks, and tx_done_o must pulse once, right after the final tick.
// Build with UART_TX_HOLD_REG_EN defined to include the back-to-back test.
// -----------------------------------------------------------------------------
module tb_uart_tx_param;

    localparam int N_BITS_DATA = 8;
    localparam int N_TICKS     = 16;

`ifdef UART_TX_HOLD_REG_EN
    localparam bit HOLD = 1'b1;
`else
    localparam bit HOLD = 1'b0;
`endif

    logic                   clock;
    logic                   reset;
    logic                   s_ticks;
    logic                   tx_valid;
    logic [N_BITS_DATA-1:0] tx_data_in;
    logic                   tx_ready;
    logic [1:0]             parity_mode;
    logic                   stop_two;
    logic                   tx_busy;
    logic                   tx_done_o;
    logic                   tx_data_out;

    int   checks = 0;
    int   errors = 0;
    logic exp_bits[$];
    logic exp_ready_mid;

    uart_tx_param #(
        .N_BITS_DATA  (N_BITS_DATA),
        .N_TICKS      (N_TICKS),
        .N_CONT_TICKS (4),
        .N_BITS_STATE (5)
    ) dut (
        .clock       (clock),
        .reset       (reset),
        .s_ticks     (s_ticks),
        .tx_valid    (tx_valid),
        .tx_data_in  (tx_data_in),
        .tx_ready    (tx_ready),
        .parity_mode (parity_mode),
        .stop_two    (stop_two),
        .tx_busy     (tx_busy),
        .tx_done_o   (tx_done_o),
        .tx_data_out (tx_data_out)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic observed, input logic expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("FAIL %s: observed %b expected %b", tag, observed, expected);
        end
    endtask

    // Expected line values, one entry per bit period.
    task automatic build_frame(input logic [N_BITS_DATA-1:0] data,
                               input logic [1:0] mode, input logic two);
        int ones;
        exp_bits.delete();
        exp_bits.push_back(1'b0);
        for (int i = 0; i < N_BITS_DATA; i++) exp_bits.push_back(data[i]);
        ones = $countones(data);
        case (mode)
            2'b01:   exp_bits.push_back((ones % 2) == 1);
            2'b10:   exp_bits.push_back((ones % 2) == 0);
            2'b11:   exp_bits.push_back(1'b0);
            default: ;
        endcase
        exp_bits.push_back(1'b1);
        if (two) exp_bits.push_back(1'b1);
    endtask

    // Called at a negedge with the DUT idle; returns at the negedge after accept.
    task automatic accept_frame(input logic [N_BITS_DATA-1:0] data,
                                input logic [1:0] mode, input logic two);
        build_frame(data, mode, two);
        check("idle ready", tx_ready, 1'b1);
        check("idle busy", tx_busy, 1'b0);
        check("idle line", tx_data_out, 1'b1);
        tx_valid    = 1'b1;
        tx_data_in  = data;
        parity_mode = mode;
        stop_two    = two;
        s_ticks     = 1'($urandom_range(0, 1));  // a tick on accept must not count
        @(negedge clock);
        tx_valid = 1'b0;
        s_ticks  = 1'b0;
    endtask

    // Deliver n_ticks baud ticks with random spacing, checking the line before
    // each one and scrambling the inputs that must no longer matter.
    task automatic run_bits(input int n_ticks);
        for (int k = 0; k < n_ticks; k++) begin
            int b;
            b = k / N_TICKS;
            repeat ($urandom_range(0, 2)) begin
                check("line between ticks", tx_data_out, exp_bits[b]);
                check("done between ticks", tx_done_o, 1'b0);
                @(negedge clock);
            end
            check($sformatf("line bit %0d tick %0d", b, k % N_TICKS), tx_data_out, exp_bits[b]);
            check("done mid-frame", tx_done_o, 1'b0);
            if (k % N_TICKS == 0) begin
                check("busy mid-frame", tx_busy, 1'b1);
                check("ready mid-frame", tx_ready, exp_ready_mid);
            end
            tx_data_in  = N_BITS_DATA'($urandom);
            parity_mode = 2'($urandom_range(0, 3));
            stop_two    = 1'($urandom_range(0, 1));
            if (!HOLD) tx_valid = 1'($urandom_range(0, 1));
            s_ticks = 1'b1;
            @(negedge clock);
            s_ticks = 1'b0;
        end
    endtask

    task automatic end_checks();
        check("done pulse", tx_done_o, 1'b1);
        check("busy after frame", tx_busy, 1'b0);
        check("line after frame", tx_data_out, 1'b1);
        check("ready after frame", tx_ready, 1'b1);
        @(negedge clock);
        check("done one cycle", tx_done_o, 1'b0);
    endtask

    task automatic send_frame(input logic [N_BITS_DATA-1:0] data,
                              input logic [1:0] mode, input logic two);
        accept_frame(data, mode, two);
        run_bits(exp_bits.size() * N_TICKS);
        tx_valid = 1'b0;
        end_checks();
    endtask

    initial begin
        reset         = 1'b1;
        s_ticks       = 1'b0;
        tx_valid      = 1'b0;
        tx_data_in    = '0;
        parity_mode   = 2'b00;
        stop_two      = 1'b0;
        exp_ready_mid = HOLD;

        repeat (3) @(negedge clock);
        check("reset line", tx_data_out, 1'b1);
        check("reset ready", tx_ready, 1'b1);
        check("reset busy", tx_busy, 1'b0);
        check("reset done", tx_done_o, 1'b0);
        reset = 1'b0;
        @(negedge clock);

        // 8N1, then parity even/odd/space on the same byte, then two stops.
        send_frame(8'hA5, 2'b00, 1'b0);
        send_frame(8'h03, 2'b01, 1'b0);
        send_frame(8'h03, 2'b10, 1'b0);
        send_frame(8'h03, 2'b11, 1'b0);
        send_frame(8'h5A, 2'b00, 1'b1);

        // Reset in the middle of data bit 4: line idles, no done pulse.
        accept_frame(8'h96, 2'b01, 1'b0);
        run_bits(5 * N_TICKS + 7);
        tx_valid = 1'b0;
        reset    = 1'b1;
        @(negedge clock);
        check("mid-frame reset line", tx_data_out, 1'b1);
        check("mid-frame reset ready", tx_ready, 1'b1);
        check("mid-frame reset busy", tx_busy, 1'b0);
        check("mid-frame reset done", tx_done_o, 1'b0);
        reset = 1'b0;
        for (int i = 0; i < 2 * N_TICKS; i++) begin
            s_ticks = 1'(i % 2);
            @(negedge clock);
            check("post-reset done", tx_done_o, 1'b0);
            check("post-reset line", tx_data_out, 1'b1);
        end
        s_ticks = 1'b0;

        send_frame(8'hC3, 2'b10, 1'b1);
        for (int i = 0; i < 8; i++)
            send_frame(N_BITS_DATA'($urandom), 2'($urandom_range(0, 3)),
                       1'($urandom_range(0, 1)));

`ifdef UART_TX_HOLD_REG_EN
        // Back-to-back frames through the holding register.
        accept_frame(8'h11, 2'b00, 1'b0);
        check("hold empty after accept", tx_ready, 1'b1);
        tx_valid    = 1'b1;
        tx_data_in  = 8'h22;
        parity_mode = 2'b01;
        stop_two    = 1'b1;
        @(negedge clock);
        tx_valid = 1'b0;
        check("hold full", tx_ready, 1'b0);
        exp_ready_mid = 1'b0;
        run_bits(exp_bits.size() * N_TICKS);
        check("first done pulse", tx_done_o, 1'b1);
        check("zero-gap start bit", tx_data_out, 1'b0);
        check("busy across frames", tx_busy, 1'b1);
        check("hold drained", tx_ready, 1'b1);
        @(negedge clock);
        check("first done one cycle", tx_done_o, 1'b0);
        build_frame(8'h22, 2'b01, 1'b1);
        exp_ready_mid = 1'b1;
        run_bits(exp_bits.size() * N_TICKS);
        end_checks();
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/uart_tx_param.md
Name: uart_tx_param

Overview:
Parametrised UART serializer; next generation of the existing fixed 8-bit, 16-tick transmitter.
- Data width, oversampling ratio, parity mode (none/even/odd/space) and 1 or 2 stop bits are configurable.
- Byte input uses a valid/ready handshake.
- Sits between the debug-unit / MIPS host interface and the serial pin, driven by the shared baud-rate tick generator.

Parameters:
- N_BITS_DATA, 8, data bits per frame (5..9).
- N_TICKS, 16, s_ticks per bit period (power of 2 not required, >=2).
- N_CONT_TICKS, 4, width of tick counter; must satisfy 2^N_CONT_TICKS >= N_TICKS.
- N_BITS_STATE, 5, one-hot state register width.

Ports:
- clock  in  1  system clock; all logic on rising edge.
- reset  in  1  synchronous, active-high reset.
- s_ticks  in  1  baud oversample strobe, one clock wide.
- tx_valid  in  1  tx_data_in holds a byte to send.
- tx_data_in  in  N_BITS_DATA  byte to transmit, LSB first.
- tx_ready  out  1  block accepts a byte this cycle.
- parity_mode  in  2  00 none, 01 even, 10 odd, 11 space (constant 0, legacy frame).
- stop_two  in  1  1 = two stop bits.
- tx_busy  out  1  frame in progress.
- tx_done_o  out  1  one-cycle pulse at end of final stop bit.
- tx_data_out  out  1  serial line, idle high.

Behaviour:
- Reset values:
  - tx_data_out=1, tx_ready=1, tx_busy=0, tx_done_o=0.
  - State IDLE; counters and shift/holding registers 0.
- Accept: tx_valid && tx_ready at a rising edge.
  - Latches tx_data_in, parity_mode and stop_two.
  - Later changes to those inputs do not affect the frame in progress.
- Latency: tx_data_out drives 0 (start bit) on the cycle after accept.
- States are one-hot: IDLE, START, DATA, PARITY, STOP.
  - IDLE -> START on accept.
  - START -> DATA after N_TICKS s_ticks.
  - DATA sends N_BITS_DATA bits, LSB first, each N_TICKS s_ticks; then -> PARITY, or -> STOP when parity_mode=00.
  - PARITY -> STOP after one bit period. Even = XOR of data bits; odd = inverted XOR; space = 0.
  - STOP holds line 1 for 1 or 2 bit periods, then -> IDLE with tx_done_o=1 for exactly one cycle.
- Tick counter advances only on s_ticks outside IDLE and wraps at N_TICKS-1. The bit counter increments on wrap. Both clear in IDLE.
- tx_busy=1 in every state except IDLE.
- Without the holding register, tx_ready=1 only in IDLE. Minimum inter-frame gap is 1 clock.
- tx_valid while not ready: ignored, no side effect. The byte must be held by the source.
- s_ticks coincident with accept: not counted; counting starts the following cycle.
- Reset mid-frame: next edge forces tx_data_out=1 and IDLE, no tx_done_o pulse, holding register emptied.
- Frame length in s_ticks: N_TICKS*(1+N_BITS_DATA+P+S), where P = 0 or 1 (parity bit present) and S = 1 or 2 (stop bits).

Optional Feature:
- Macro: UART_TX_HOLD_REG_EN.
- Defined: adds a one-entry holding register with its own config copy.
  - tx_ready = holding register empty.
  - A byte can be accepted mid-frame.
  - At the end of STOP with the holding register full, the FSM goes directly to START with no idle cycle (line goes 1 -> 0 on the next clock).
  - tx_done_o still pulses per frame.
- Undefined: no holding register; tx_ready follows IDLE only, as above.

Decomposition:
- Package uart_pkg: parity mode constants (PAR_NONE, PAR_EVEN, PAR_ODD, PAR_SPACE) and one-hot state encodings, shared with the future parametrised rx.
- Sub-module uart_bit_timer: tick counter plus bit counter, with clear and enable inputs and a bit_end strobe output. The FSM and shifter remain in uart_tx_param.

Test Plan:
- 8N1, N_TICKS=16, tx_data_in=8'hA5 -> line reads 0,1,0,1,0,0,1,0,1,1, each 16 s_ticks; tx_done_o pulses once after 160 s_ticks.
- parity_mode=01, data 8'h03 -> parity bit 0; parity_mode=10, same data -> parity bit 1; 11-bit frame.
- stop_two=1, parity_mode=00 -> stop high for 32 s_ticks; tx_busy falls with tx_done_o.
- reset asserted during DATA bit 4 -> next clock tx_data_out=1, tx_ready=1, no tx_done_o pulse.
- parity_mode/stop_two/tx_data_in toggled mid-frame -> frame unchanged.
- UART_TX_HOLD_REG_EN defined: 8'h11 then 8'h22 offered back-to-back -> second start bit begins the clock after the first stop ends, zero gap; two tx_done_o pulses.
